// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle sequencer for the shared single-ALU,
// single-memory MIPS datapath. Each instruction walks IF -> ID -> EXE ->
// MEM -> WB as needed. The unit issues per-state write enables and mux
// selects, and guards every memory access with a wait-cycle timeout.
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   - undefined op/func in ID traps; sticky 'illegal' port added.
//   undefined - undefined op/func retires as a NOP from ID.
module mc_control_unit #(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       wir,
  output logic       wpc,
  output logic [1:0] pcsrc,
  output logic       wmem,
  output logic       wreg,
  output logic       regrt,
  output logic       mem2reg,
  output logic       aluimm,
  output logic       shift,
  output logic       s_ext,
  output logic       jal,
  output logic [3:0] aluc,
  output logic [2:0] state,
  output logic       retire,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output logic       mem_err
);

  // WIDTH documents the datapath this unit steers; no logic depends on it.
  if (WIDTH < 1) begin : g_width_doc
  end

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b101
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [3:0] ALU_LUI = 4'b0110;

  // The counter only needs to reach MEM_TIMEOUT-1: the wait cycle seen at
  // that count is the last one allowed.
  localparam int            CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit            TO_EN = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t        cur_state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic          limit_reached;
  logic          timeout_trap;
  logic          mem_err_q;

  // Instruction class and ALU controls decoded from op/func.
  logic       r_alu, i_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  logic       legal;
  logic [3:0] dec_aluc;
  logic       dec_aluimm, dec_shift, dec_sext;

  // Raw (ungated) enables; reset masking happens on the ports.
  logic mreq_i, wir_i, wpc_i, wmem_i, wreg_i, retire_i;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_set;
  logic illegal_q;
`endif

  // Opcode/function decode shared with the single-cycle control path.
  always_comb begin
    r_alu      = 1'b0;
    i_alu      = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    dec_aluc   = ALU_ADD;
    dec_aluimm = 1'b0;
    dec_shift  = 1'b0;
    dec_sext   = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          F_ADD:   begin r_alu = 1'b1; dec_aluc = ALU_ADD; end
          F_SUB:   begin r_alu = 1'b1; dec_aluc = ALU_SUB; end
          F_AND:   begin r_alu = 1'b1; dec_aluc = ALU_AND; end
          F_OR:    begin r_alu = 1'b1; dec_aluc = ALU_OR;  end
          F_XOR:   begin r_alu = 1'b1; dec_aluc = ALU_XOR; end
          F_SLL:   begin r_alu = 1'b1; dec_aluc = ALU_SLL; dec_shift = 1'b1; end
          F_SRL:   begin r_alu = 1'b1; dec_aluc = ALU_SRL; dec_shift = 1'b1; end
          F_SRA:   begin r_alu = 1'b1; dec_aluc = ALU_SRA; dec_shift = 1'b1; end
          F_JR:    begin is_jr = 1'b1; end
          default: begin r_alu = 1'b0; end
        endcase
      end
      OP_ADDI: begin i_alu = 1'b1; dec_aluc = ALU_ADD; dec_aluimm = 1'b1; dec_sext = 1'b1; end
      OP_ANDI: begin i_alu = 1'b1; dec_aluc = ALU_AND; dec_aluimm = 1'b1; end
      OP_ORI:  begin i_alu = 1'b1; dec_aluc = ALU_OR;  dec_aluimm = 1'b1; end
      OP_XORI: begin i_alu = 1'b1; dec_aluc = ALU_XOR; dec_aluimm = 1'b1; end
      OP_LUI:  begin i_alu = 1'b1; dec_aluc = ALU_LUI; dec_aluimm = 1'b1; end
      OP_LW:   begin is_lw = 1'b1; dec_aluc = ALU_ADD; dec_aluimm = 1'b1; dec_sext = 1'b1; end
      OP_SW:   begin is_sw = 1'b1; dec_aluc = ALU_ADD; dec_aluimm = 1'b1; dec_sext = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; dec_aluc = ALU_SUB; dec_sext = 1'b1; end
      OP_BNE:  begin is_bne = 1'b1; dec_aluc = ALU_SUB; dec_sext = 1'b1; end
      OP_J:    begin is_j = 1'b1; end
      OP_JAL:  begin is_jal = 1'b1; end
      default: begin r_alu = 1'b0; end
    endcase
    legal = r_alu | i_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal | is_jr;
  end

  assign limit_reached = TO_EN && (wait_cnt == LIMIT);

  // Next-state and per-state control outputs.
  always_comb begin
    next_state   = cur_state;
    mreq_i       = 1'b0;
    wir_i        = 1'b0;
    wpc_i        = 1'b0;
    wmem_i       = 1'b0;
    wreg_i       = 1'b0;
    retire_i     = 1'b0;
    iord         = 1'b0;
    pcsrc        = 2'b00;
    regrt        = 1'b0;
    mem2reg      = 1'b0;
    aluimm       = 1'b0;
    shift        = 1'b0;
    s_ext        = 1'b0;
    jal          = 1'b0;
    aluc         = 4'b0000;
    timeout_trap = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_set  = 1'b0;
`endif
    case (cur_state)
      S_IF: begin
        mreq_i = 1'b1;
        if (mem_ready) begin
          wir_i      = 1'b1;
          wpc_i      = 1'b1;
          next_state = S_ID;
        end else if (limit_reached) begin
          timeout_trap = 1'b1;
          next_state   = S_TRAP;
        end else begin
          next_state = S_IF;
        end
      end
      S_ID: begin
        if (is_j || is_jal) begin
          wpc_i      = 1'b1;
          pcsrc      = 2'b11;
          wreg_i     = is_jal;
          jal        = is_jal;
          retire_i   = 1'b1;
          next_state = S_IF;
        end else if (is_jr) begin
          wpc_i      = 1'b1;
          pcsrc      = 2'b10;
          retire_i   = 1'b1;
          next_state = S_IF;
        end else if (legal) begin
          next_state = S_EXE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          illegal_set = 1'b1;
          next_state  = S_TRAP;
`else
          retire_i   = 1'b1;
          next_state = S_IF;
`endif
        end
      end
      S_EXE: begin
        aluc   = dec_aluc;
        aluimm = dec_aluimm;
        shift  = dec_shift;
        s_ext  = dec_sext;
        if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else if (is_beq || is_bne) begin
          retire_i   = 1'b1;
          next_state = S_IF;
          if ((is_beq && z) || (is_bne && !z)) begin
            wpc_i = 1'b1;
            pcsrc = 2'b01;
          end else begin
            wpc_i = 1'b0;
          end
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mreq_i = 1'b1;
        iord   = 1'b1;
        wmem_i = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            next_state = S_WB;
          end else begin
            retire_i   = 1'b1;
            next_state = S_IF;
          end
        end else if (limit_reached) begin
          timeout_trap = 1'b1;
          next_state   = S_TRAP;
        end else begin
          next_state = S_MEM;
        end
      end
      S_WB: begin
        aluc       = dec_aluc;
        aluimm     = dec_aluimm;
        shift      = dec_shift;
        s_ext      = dec_sext;
        wreg_i     = 1'b1;
        regrt      = is_lw | i_alu;
        mem2reg    = is_lw;
        retire_i   = 1'b1;
        next_state = S_IF;
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_IF;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cur_state <= S_IF;
    end else begin
      cur_state <= next_state;
    end
  end

  // Wait counter: restarts on every state entry, counts stalled request cycles.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_cnt <= '0;
    end else if (next_state != cur_state) begin
      wait_cnt <= '0;
    end else if (TO_EN && mreq_i && !mem_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Sticky memory-timeout flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= mem_err_q | timeout_trap;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_q | illegal_set;
    end
  end

  assign illegal = illegal_q;
`endif

  // Write enables and the request are masked for the whole reset interval.
  assign mem_req = mreq_i   & clrn;
  assign wir     = wir_i    & clrn;
  assign wpc     = wpc_i    & clrn;
  assign wmem    = wmem_i   & clrn;
  assign wreg    = wreg_i   & clrn;
  assign retire  = retire_i & clrn;
  assign state   = cur_state;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit (MEM_TIMEOUT = 4).
module tb_mc_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_JR    = 6'b001000;

  logic       clk, clrn, z, mem_ready;
  logic [5:0] op, func;
  logic       mem_req, iord, wir, wpc, wmem, wreg, regrt, mem2reg;
  logic       aluimm, shift, s_ext, jal, retire, mem_err;
  logic [1:0] pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mc_control_unit #(.WIDTH(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .wir(wir), .wpc(wpc), .pcsrc(pcsrc),
    .wmem(wmem), .wreg(wreg), .regrt(regrt), .mem2reg(mem2reg),
    .aluimm(aluimm), .shift(shift), .s_ext(s_ext), .jal(jal), .aluc(aluc),
    .state(state), .retire(retire),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic zz, input logic rdy);
    op = o; func = f; z = zz; mem_ready = rdy;
    #1;
  endtask

  // Field groups: g1={mem_req,iord,wir,wpc} g2={wmem,wreg,regrt,mem2reg}
  //               g3={aluimm,shift,s_ext,jal}
  task automatic ex(input string tag, input logic [2:0] st, input logic [3:0] g1,
                    input logic [1:0] pcs, input logic [3:0] g2, input logic [3:0] g3,
                    input logic [3:0] alu, input logic ret);
    logic [21:0] obs, exp;
    obs = {state, mem_req, iord, wir, wpc, pcsrc, wmem, wreg, regrt, mem2reg,
           aluimm, shift, s_ext, jal, aluc, retire};
    exp = {st, g1, pcs, g2, g3, alu, ret};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clrn = 1'b0;
    drive(OP_R, 6'b000000, 1'b0, 1'b0);
    ex("reset outputs", 3'd0, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("reset mem_err", mem_err, 1'b0);
    #10;
    clrn = 1'b1;
    #1;
    ex("post-reset IF", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc;

    // add, zero-wait: IF ID EXE WB
    drive(OP_R, F_ADD, 1'b0, 1'b1);
    ex("add IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_R, F_ADD, 1'b0, 1'b0);
    ex("add ID", 3'd1, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc;
    ex("add EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc;
    ex("add WB", 3'd4, 4'b0000, 2'b00, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    cyc;
    ex("add next IF", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // sra after two stalled fetch cycles
    drive(OP_R, F_SRA, 1'b0, 1'b0);
    cyc;
    ex("sra IF hold", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_R, F_SRA, 1'b0, 1'b1);
    ex("sra IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_R, F_SRA, 1'b0, 1'b0);
    cyc;
    ex("sra EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b0100, 4'b1111, 1'b0);
    cyc;
    ex("sra WB", 3'd4, 4'b0000, 2'b00, 4'b0100, 4'b0100, 4'b1111, 1'b1);
    cyc;

    // ori: zero-extended immediate, writes rt
    drive(OP_ORI, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_ORI, 6'b000000, 1'b0, 1'b0);
    cyc;
    ex("ori EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b1000, 4'b0101, 1'b0);
    cyc;
    ex("ori WB", 3'd4, 4'b0000, 2'b00, 4'b0110, 4'b1000, 4'b0101, 1'b1);
    cyc;

    // lw with three wait cycles in MEM (ready on the limit cycle wins)
    drive(OP_LW, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_LW, 6'b000000, 1'b0, 1'b0);
    cyc;
    ex("lw EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b1010, 4'b0000, 1'b0);
    cyc;
    for (int i = 0; i < 3; i++) begin
      ex("lw MEM wait", 3'd3, 4'b1100, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      cyc;
    end
    drive(OP_LW, 6'b000000, 1'b0, 1'b1);
    ex("lw MEM ready", 3'd3, 4'b1100, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_LW, 6'b000000, 1'b0, 1'b0);
    ex("lw WB", 3'd4, 4'b0000, 2'b00, 4'b0111, 4'b1010, 4'b0000, 1'b1);
    chk1("lw no timeout", mem_err, 1'b0);
    cyc;

    // beq taken, beq not taken, bne taken
    drive(OP_BEQ, 6'b000000, 1'b1, 1'b1);
    cyc; drive(OP_BEQ, 6'b000000, 1'b1, 1'b0);
    cyc;
    ex("beq taken EXE", 3'd2, 4'b0001, 2'b01, 4'b0000, 4'b0010, 4'b0100, 1'b1);
    cyc; drive(OP_BEQ, 6'b000000, 1'b0, 1'b1);
    ex("beq back to IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_BEQ, 6'b000000, 1'b0, 1'b0);
    cyc;
    ex("beq not taken EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b0010, 4'b0100, 1'b1);
    cyc; drive(OP_BNE, 6'b000000, 1'b0, 1'b1);
    ex("beq nt back to IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc; drive(OP_BNE, 6'b000000, 1'b0, 1'b0);
    cyc;
    ex("bne taken EXE", 3'd2, 4'b0001, 2'b01, 4'b0000, 4'b0010, 4'b0100, 1'b1);
    cyc;

    // jal, jr, j complete in ID
    drive(OP_JAL, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_JAL, 6'b000000, 1'b0, 1'b0);
    ex("jal ID", 3'd1, 4'b0001, 2'b11, 4'b0100, 4'b0001, 4'b0000, 1'b1);
    cyc;
    ex("jal next IF", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    drive(OP_R, F_JR, 1'b0, 1'b1);
    cyc; drive(OP_R, F_JR, 1'b0, 1'b0);
    ex("jr ID", 3'd1, 4'b0001, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc; drive(OP_J, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_J, 6'b000000, 1'b0, 1'b0);
    ex("j ID", 3'd1, 4'b0001, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc;

    // undefined opcode
    drive(OP_BAD, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_BAD, 6'b000000, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    ex("illegal ID", 3'd1, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc;
    ex("illegal TRAP", 3'd5, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("illegal flag", illegal, 1'b1);
    clrn = 1'b0; #1; clrn = 1'b1; #1;
`else
    ex("illegal ID nop", 3'd1, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    cyc;
    ex("illegal next IF", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

    // sw zero-wait: retires from MEM
    drive(OP_SW, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_SW, 6'b000000, 1'b0, 1'b0);
    cyc;
    ex("sw EXE", 3'd2, 4'b0000, 2'b00, 4'b0000, 4'b1010, 4'b0000, 1'b0);
    cyc; drive(OP_SW, 6'b000000, 1'b0, 1'b1);
    ex("sw MEM ready", 3'd3, 4'b1100, 2'b00, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    cyc;
    ex("sw next IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // reset pulse in the middle of sw MEM
    cyc; drive(OP_SW, 6'b000000, 1'b0, 1'b0);
    cyc; cyc;
    ex("sw MEM pre-reset", 3'd3, 4'b1100, 2'b00, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    clrn = 1'b0; #1;
    ex("mid-MEM reset", 3'd0, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    clrn = 1'b1; #1;
    ex("after reset IF", 3'd0, 4'b1000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    cyc;

    // sw with memory never ready: four wait cycles then TRAP
    drive(OP_SW, 6'b000000, 1'b0, 1'b1);
    cyc; drive(OP_SW, 6'b000000, 1'b0, 1'b0);
    cyc; cyc;
    for (int i = 0; i < 4; i++) begin
      ex("sw MEM stall", 3'd3, 4'b1100, 2'b00, 4'b1000, 4'b0000, 4'b0000, 1'b0);
      cyc;
    end
    ex("timeout TRAP", 3'd5, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("timeout mem_err", mem_err, 1'b1);
    drive(OP_SW, 6'b000000, 1'b0, 1'b1);
    cyc; cyc;
    ex("TRAP holds", 3'd5, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("mem_err sticky", mem_err, 1'b1);
    clrn = 1'b0; #1;
    ex("trap reset", 3'd0, 4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk1("reset clears mem_err", mem_err, 1'b0);
    clrn = 1'b1; #1;
    ex("recovered IF", 3'd0, 4'b1011, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle sequencer for the shared single-ALU, single-memory MIPS datapath.
- Steps each instruction through the IF, ID, EXE, MEM and WB states, issuing per-state write enables and mux selects.
- Handles a variable-latency memory handshake with a timeout.
- Uses the same opcode/func decode and aluc encoding as the single-cycle control path.

Parameters:
- WIDTH, 32, datapath width; informational only, no logic depends on it.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready per access; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- op  input  6  IR[31:26]; valid from ID onward.
- func  input  6  IR[5:0].
- z  input  1  ALU zero flag; valid in EXE.
- mem_ready  input  1  memory access complete this cycle.
- mem_req  output  1  memory access request.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
- wir  output  1  IR load enable.
- wpc  output  1  PC load enable.
- pcsrc  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- wmem  output  1  memory write.
- wreg  output  1  register-file write.
- regrt  output  1  destination register: 1 = rt, 0 = rd.
- mem2reg  output  1  writeback source: 1 = memory data register.
- aluimm  output  1  ALU B operand = extended immediate.
- shift  output  1  ALU A operand = shamt.
- s_ext  output  1  sign-extend the immediate.
- jal  output  1  write PC+4 to r31.
- aluc  output  4  ALU operation code.
- state  output  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, TRAP=101.
- retire  output  1  one-cycle pulse on the last cycle of each completed instruction.
- mem_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (clrn=0, asynchronous): state=IF, wait counter=0, mem_err=0.
  - While clrn=0, wpc, wir, wreg, wmem, mem_req and retire are forced to 0.
  - All other outputs are decoded combinationally from state, op, func and z; default value 0.
- aluc codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, SLL 0011, SRL 0111, SRA 1111, LUI 0110.
- IF: mem_req=1, iord=0, pcsrc=00.
  - If mem_ready=1: wir=1, wpc=1, go to ID.
  - Otherwise hold in IF.
- ID:
  - j: wpc=1, pcsrc=11, retire=1, go to IF.
  - jal: same as j, plus wreg=1 and jal=1.
  - jr (op=0, func=001000): wpc=1, pcsrc=10, retire=1, go to IF.
  - All other legal instructions: go to EXE.
- EXE: drives aluc, aluimm, shift and s_ext for the instruction.
  - R-type ALU ops and addi/andi/ori/xori/lui: go to WB.
  - lw/sw: aluc=0000, aluimm=1, s_ext=1, go to MEM.
  - beq/bne: aluc=0100, s_ext=1, retire=1, go to IF.
    - beq: wpc=1 and pcsrc=01 if z=1.
    - bne: wpc=1 and pcsrc=01 if z=0.
- MEM: mem_req=1, iord=1; wmem=1 for sw for every cycle in MEM.
  - Hold until mem_ready=1.
  - On mem_ready, lw goes to WB; sw sets retire=1 and goes to IF.
- WB: wreg=1, retire=1, go to IF.
  - lw: regrt=1, mem2reg=1.
  - I-type ALU ops: regrt=1.
  - R-type: regrt=0.
  - aluc and selects remain those of EXE.
- Cycle counts with zero-wait memory: lw 5; R-type, I-type ALU and sw 4; branches 3; j/jal/jr 2.
- Timeout (MEM_TIMEOUT>0):
  - The counter clears on entry to IF or MEM and increments each cycle mem_ready=0 while mem_req=1.
  - Reaching MEM_TIMEOUT sets mem_err=1 and moves to TRAP.
  - mem_ready arriving on the same cycle as the limit wins: normal transition, no error.
- TRAP: all enables 0. TRAP is exited only by reset.
- Illegal op/func handling is set by ILLEGAL_TRAP_EN.
- No cycle is lost between instructions: the retire cycle is followed immediately by IF.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An undefined op, or op=0 with an undefined func, in ID goes to TRAP.
  - Output illegal (1 bit, added port) asserts and stays asserted until reset.
- Undefined: the instruction executes as a NOP in ID (retire=1, go to IF), and the illegal port is absent.

Test Plan:
- add (op=0, func=100000), zero-wait memory -> states IF,ID,EXE,WB.
  - WB: wreg=1, regrt=0, aluc=0000.
  - retire pulses once; 4 cycles total.
- lw with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, iord=1; then WB with mem2reg=1, regrt=1; total 8 cycles.
- beq with z=1, then with z=0 -> taken: wpc=1, pcsrc=01 in EXE. Not taken: wpc=0. Both return to IF after 3 cycles.
- jal -> ID cycle shows wpc=1, pcsrc=11, wreg=1, jal=1, retire=1; next state is IF.
- MEM_TIMEOUT=4, mem_ready held 0 during sw -> mem_err=1 after 4 wait cycles; state=101; wmem=0 thereafter; only clrn=0 recovers.
- clrn pulsed low mid-MEM of sw -> immediate state=000 and wmem=0; after release, IF with mem_req=1.
